// File: rtl/data_mem_ctrl_pkg.sv
// Shared opcode constants, controller state encoding and helpers for the
// data-side memory controller.
package data_mem_ctrl_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] LB  = 4'd0;
  localparam logic [OP_W-1:0] LH  = 4'd1;
  localparam logic [OP_W-1:0] LW  = 4'd2;
  localparam logic [OP_W-1:0] LBU = 4'd3;
  localparam logic [OP_W-1:0] LHU = 4'd4;
  localparam logic [OP_W-1:0] SB  = 4'd5;
  localparam logic [OP_W-1:0] SH  = 4'd6;
  localparam logic [OP_W-1:0] SW  = 4'd7;

  typedef enum logic [1:0] {
    DMC_IDLE  = 2'd0,
    DMC_READ  = 2'd1,
    DMC_WRITE = 2'd2
  } dmc_state_t;

  localparam logic [31:0] IO_BASE = 32'h30000;

  // Anything other than 1 or 2 bytes is a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    logic [2:0] n;
    case (len)
      3'd1:    n = 3'd1;
      3'd2:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_load_extend.sv
// Sign/zero extension of an assembled little-endian load value by opcode.
module data_mem_ctrl_load_extend
  import data_mem_ctrl_pkg::*;
(
  input  logic [31:0]     raw,
  input  logic [OP_W-1:0] op,
  output logic [31:0]     result
);

  always_comb begin
    case (op)
      LB:      result = {{24{raw[7]}}, raw[7:0]};
      LH:      result = {{16{raw[15]}}, raw[15:0]};
      LBU:     result = {24'b0, raw[7:0]};
      LHU:     result = {16'b0, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: serialises one load/store request into
// byte-wide RAM accesses and returns an extended load result with a pulse.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             br_flag,
  input  logic             lsb_en_i,
  input  logic             lsb_rwen_i,
  input  logic [OP_W-1:0]  lsb_op_i,
  input  logic [2:0]       lsb_len_i,
  input  logic [ADR_W-1:0] lsb_adr_i,
  input  logic [DAT_W-1:0] lsb_dat_i,
  output logic             lsb_en_o,
  output logic [DAT_W-1:0] lsb_dat_o,
  input  logic [7:0]       mem_din_i,
  output logic [7:0]       mem_dout_o,
  output logic [ADR_W-1:0] mem_a_o,
  output logic             mem_wr_o
);

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  dmc_state_t       state_reg, state_next;
  logic [OP_W-1:0]  op_reg, op_next;
  logic [2:0]       len_reg, len_next;
  logic [2:0]       cnt_reg, cnt_next;
  logic [ADR_W-1:0] adr_reg, adr_next;
  logic [ADR_W-1:0] mem_a_reg, mem_a_next;
  logic [DAT_W-1:0] dat_reg, dat_next;
  logic [DAT_W-1:0] buf_reg, buf_next;
  logic [DAT_W-1:0] res_reg, res_next;
  logic [7:0]       dout_reg, dout_next;
  logic             wr_reg, wr_next;
  logic             done_reg, done_next;

  logic [2:0]       cnt_inc;
  logic [2:0]       rd_idx;
  logic             rd_valid;
  logic             write_last;
  logic             read_last;
  logic             accept;
  logic [DAT_W-1:0] dat_shift;
  logic [DAT_W-1:0] rd_raw;
  logic [DAT_W-1:0] ext_res;

  // In READ, cnt counts issued addresses; the byte on mem_din_i belongs to
  // the address issued LAT cycles earlier.
  assign cnt_inc    = cnt_reg + 3'd1;
  assign rd_idx     = cnt_reg - LAT;
  assign rd_valid   = (cnt_reg >= LAT);
  assign write_last = (cnt_inc == len_reg);
  assign read_last  = (cnt_reg == len_reg + LAT - 3'd1);
  assign accept     = lsb_en_i && (lsb_rwen_i || !br_flag);
  assign dat_shift  = dat_reg >> {cnt_inc, 3'b000};
  assign rd_raw     = buf_reg | (rd_valid ? (DAT_W'(mem_din_i) << {rd_idx, 3'b000}) : '0);

  data_mem_ctrl_load_extend u_load_extend (
    .raw    (rd_raw),
    .op     (op_reg),
    .result (ext_res)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= DMC_IDLE;
      op_reg    <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      adr_reg   <= '0;
      mem_a_reg <= '0;
      dat_reg   <= '0;
      buf_reg   <= '0;
      res_reg   <= '0;
      dout_reg  <= '0;
      wr_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else if (en) begin
      state_reg <= state_next;
      op_reg    <= op_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      adr_reg   <= adr_next;
      mem_a_reg <= mem_a_next;
      dat_reg   <= dat_next;
      buf_reg   <= buf_next;
      res_reg   <= res_next;
      dout_reg  <= dout_next;
      wr_reg    <= wr_next;
      done_reg  <= done_next;
    end
  end

  // Committed stores ignore a flush; loads in flight are dropped by it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DMC_IDLE:  if (accept) state_next = lsb_rwen_i ? DMC_WRITE : DMC_READ;
      DMC_WRITE: if (write_last) state_next = DMC_IDLE;
      DMC_READ:  if (br_flag || read_last) state_next = DMC_IDLE;
      default:   state_next = DMC_IDLE;
    endcase
  end

  always_comb begin
    op_next    = op_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    adr_next   = adr_reg;
    mem_a_next = mem_a_reg;
    dat_next   = dat_reg;
    buf_next   = buf_reg;
    dout_next  = dout_reg;
    wr_next    = 1'b0;
    done_next  = 1'b0;
    res_next   = '0;
    case (state_reg)
      DMC_IDLE: begin
        if (accept) begin
          op_next    = lsb_op_i;
          len_next   = norm_len(lsb_len_i);
          adr_next   = lsb_adr_i;
          dat_next   = lsb_dat_i;
          cnt_next   = '0;
          buf_next   = '0;
          mem_a_next = lsb_adr_i;
          wr_next    = lsb_rwen_i;
          if (lsb_rwen_i) dout_next = lsb_dat_i[7:0];
        end
      end
      DMC_WRITE: begin
        if (write_last) begin
          done_next = 1'b1;
        end else begin
          cnt_next   = cnt_inc;
          mem_a_next = adr_reg + ADR_W'(cnt_inc);
          dout_next  = dat_shift[7:0];
          wr_next    = 1'b1;
        end
      end
      DMC_READ: begin
        if (!br_flag) begin
          cnt_next = cnt_inc;
          buf_next = rd_raw;
          if (cnt_inc < len_reg) mem_a_next = adr_reg + ADR_W'(cnt_inc);
          if (read_last) begin
            done_next = 1'b1;
            res_next  = ext_res;
          end
        end
      end
      default: ;
    endcase
  end

  assign lsb_en_o   = done_reg;
  assign lsb_dat_o  = res_reg;
  assign mem_dout_o = dout_reg;
  assign mem_a_o    = mem_a_reg;
  assign mem_wr_o   = wr_reg & en;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised bench for data_mem_ctrl against a byte-array memory model and
// a per-request expectation derived from the access rules.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  logic            clk;
  logic            rst;
  logic            en;
  logic            br_flag;
  logic            lsb_en_i;
  logic            lsb_rwen_i;
  logic [OP_W-1:0] lsb_op_i;
  logic [2:0]      lsb_len_i;
  logic [31:0]     lsb_adr_i;
  logic [31:0]     lsb_dat_i;
  logic            lsb_en_o;
  logic [31:0]     lsb_dat_o;
  logic [7:0]      mem_din;
  logic [7:0]      mem_dout_o;
  logic [31:0]     mem_a_o;
  logic            mem_wr_o;

  int total = 0;
  int bad = 0;
  int txn_no = 0;

  logic [7:0]  ref_mem [1024];
  logic [7:0]  ram [1024];
  bit          ram_ready = 1'b0;
  logic [31:0] last_a;
  bit          last_a_known;

  data_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .br_flag    (br_flag),
    .lsb_en_i   (lsb_en_i),
    .lsb_rwen_i (lsb_rwen_i),
    .lsb_op_i   (lsb_op_i),
    .lsb_len_i  (lsb_len_i),
    .lsb_adr_i  (lsb_adr_i),
    .lsb_dat_i  (lsb_dat_i),
    .lsb_en_o   (lsb_en_o),
    .lsb_dat_o  (lsb_dat_o),
    .mem_din_i  (mem_din),
    .mem_dout_o (mem_dout_o),
    .mem_a_o    (mem_a_o),
    .mem_wr_o   (mem_wr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 73 + 41) ^ (i >> 3));
  endfunction

  // RAM with one-cycle registered read; it shares the global ready.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
      ram_ready <= 1'b1;
    end else if (en) begin
      if (mem_wr_o) ram[mem_a_o[9:0]] <= mem_dout_o;
      mem_din <= ram[mem_a_o[9:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int op_len(input logic [OP_W-1:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  // Expected load value: little-endian bytes, then extended by opcode.
  function automatic logic [31:0] ref_load(input logic [OP_W-1:0] op, input logic [31:0] adr, input int n);
    longint v;
    logic [31:0] a;
    v = 0;
    for (int i = 0; i < n; i++) begin
      a = adr + 32'(i);
      v += longint'(ref_mem[a[9:0]]) << (8 * i);
    end
    if ((op == LB || op == LH) && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  // Caller is just after a falling edge with en=1; returns likewise, in the
  // cycle where the controller is idle again (pulse cycle for completions).
  task automatic run_txn(input bit rwen, input logic [OP_W-1:0] op, input logic [2:0] len,
                         input logic [31:0] adr, input logic [31:0] dat,
                         input int br_k, input int stall_k);
    int n, e, wall, stall_left, end_e;
    bit en_was, finished, aborted, dropped;
    logic [31:0] exp_v, a, ea;
    n = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
    dropped = !rwen && br_k == 0;
    aborted = !rwen && br_k >= 0;
    end_e = rwen ? n + 1 : (aborted ? br_k + 1 : n + 2);
    exp_v = rwen ? 32'd0 : ref_load(op, adr, n);
    lsb_en_i = 1'b1; lsb_rwen_i = rwen; lsb_op_i = op; lsb_len_i = len;
    lsb_adr_i = adr; lsb_dat_i = dat; br_flag = (br_k == 0);
    e = 0; wall = 0; stall_left = 2; en_was = 1'b1; finished = 1'b0;
    while (!finished && wall < 40) begin
      @(negedge clk);
      wall++;
      if (en_was) e++;
      lsb_en_i = 1'b0;
      br_flag = 1'b0;
      en = !(e == stall_k && stall_left > 0);
      if (!en) stall_left--;
      en_was = en;
      #1;
      if (!en) begin
        check("stall_wr", 32'(mem_wr_o), 32'd0);
      end else if (e == end_e) begin
        finished = 1'b1;
        if (aborted) begin
          check("abort_nopulse", 32'(lsb_en_o), 32'd0);
          check("abort_wr", 32'(mem_wr_o), 32'd0);
          if (dropped && last_a_known) check("idle_hold_a", mem_a_o, last_a);
        end else begin
          check("pulse", 32'(lsb_en_o), 32'd1);
          check("result", lsb_dat_o, exp_v);
        end
      end else begin
        if (br_k == e) br_flag = 1'b1;
        check("pulse_early", 32'(lsb_en_o), 32'd0);
        if (e <= n) begin
          ea = adr + 32'(e - 1);
          check("addr", mem_a_o, ea);
          check("wr", 32'(mem_wr_o), 32'(rwen));
          if (rwen) check("wdata", 32'(mem_dout_o), (dat >> (8 * (e - 1))) & 32'hFF);
        end else begin
          check("wr_idle", 32'(mem_wr_o), 32'd0);
        end
      end
    end
    if (!finished) check("done_by", 32'(e), 32'(end_e));
    en = 1'b1;
    if (rwen) begin
      for (int i = 0; i < n; i++) begin
        a = adr + 32'(i);
        ref_mem[a[9:0]] = 8'(dat >> (8 * i));
      end
    end
    if (!aborted) begin
      last_a = adr + 32'(n - 1);
      last_a_known = 1'b1;
    end else if (!dropped) begin
      last_a_known = 1'b0;
    end
    txn_no++;
    $display("txn %0d: %s op=%0d len=%0d adr=%h dat=%h br=%0d stall=%0d %s lsb_dat_o=%h",
             txn_no, rwen ? "store" : "load", op, len, adr, dat, br_k, stall_k,
             aborted ? "aborted" : "completed", lsb_dat_o);
  endtask

  initial begin
    logic [OP_W-1:0] op;
    logic [2:0] len;
    logic [31:0] adr;
    bit rw;
    int n, br_k, stall_k;

    clk = 1'b0; rst = 1'b0; en = 1'b1; br_flag = 1'b0;
    lsb_en_i = 1'b0; lsb_rwen_i = 1'b0; lsb_op_i = '0; lsb_len_i = '0;
    lsb_adr_i = '0; lsb_dat_i = '0;
    last_a = '0; last_a_known = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);

    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_en_o", 32'(lsb_en_o), 32'd0);
    check("rst_dat_o", lsb_dat_o, 32'd0);
    check("rst_a", mem_a_o, 32'd0);
    check("rst_wr", 32'(mem_wr_o), 32'd0);
    check("rst_dout", 32'(mem_dout_o), 32'd0);

    run_txn(1, SW, 3'd4, 32'h100, 32'h12345678, -1, -1);
    run_txn(0, LW, 3'd4, 32'h100, 32'h0, -1, -1);
    run_txn(1, SB, 3'd1, 32'h200, 32'h00000080, -1, -1);
    run_txn(0, LB, 3'd1, 32'h200, 32'h0, -1, -1);
    run_txn(0, LBU, 3'd1, 32'h200, 32'h0, -1, -1);
    run_txn(1, SH, 3'd2, 32'h3FE, 32'h0000BEEF, -1, -1);
    run_txn(0, LHU, 3'd2, 32'h3FE, 32'h0, -1, -1);
    run_txn(0, LH, 3'd2, 32'h3FE, 32'h0, -1, -1);
    run_txn(0, LW, 3'd4, 32'h100, 32'h0, 2, -1);
    run_txn(1, SW, 3'd4, 32'h300, 32'hDEADBEEF, 1, -1);
    run_txn(0, LW, 3'd4, 32'h300, 32'h0, -1, 3);
    run_txn(0, LW, 3'd4, 32'h104, 32'h0, 0, -1);
    run_txn(1, SB, 3'd1, 32'h010, 32'h0000005A, 0, -1);
    run_txn(1, SW, 3'd4, 32'hFFFFFFFE, 32'hA1B2C3D4, -1, -1);
    run_txn(0, LW, 3'd4, 32'hFFFFFFFE, 32'h0, -1, -1);
    run_txn(0, LW, 3'd3, 32'h100, 32'h0, -1, -1);

    // Reset (with en low) while a load is in flight.
    lsb_en_i = 1'b1; lsb_rwen_i = 1'b0; lsb_op_i = LW; lsb_len_i = 3'd4;
    lsb_adr_i = 32'h120; lsb_dat_i = '0;
    @(negedge clk); lsb_en_i = 1'b0;
    @(negedge clk); rst = 1'b0; en = 1'b0;
    @(negedge clk); rst = 1'b1; en = 1'b1;
    #1;
    check("mrst_en_o", 32'(lsb_en_o), 32'd0);
    check("mrst_dat_o", lsb_dat_o, 32'd0);
    check("mrst_a", mem_a_o, 32'd0);
    check("mrst_wr", 32'(mem_wr_o), 32'd0);
    check("mrst_dout", 32'(mem_dout_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      check("mrst_nopulse", 32'(lsb_en_o), 32'd0);
    end
    $display("txn %0d: load adr=00000120 abandoned by reset", ++txn_no);
    last_a = '0; last_a_known = 1'b1;

    for (int k = 0; k < 150; k++) begin
      rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, rw ? 2 : 4))
        0: op = rw ? SB : LB;
        1: op = rw ? SH : LH;
        2: op = rw ? SW : LW;
        3: op = LBU;
        default: op = LHU;
      endcase
      n = op_len(op);
      len = 3'(n);
      if (n == 4 && $urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 4))
          0: len = 3'd0;
          1: len = 3'd3;
          2: len = 3'd5;
          3: len = 3'd6;
          default: len = 3'd7;
        endcase
      end
      adr = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7))) : $urandom;
      br_k = -1;
      stall_k = -1;
      if ($urandom_range(0, 4) == 0) br_k = $urandom_range(0, rw ? n : n + 1);
      if ($urandom_range(0, 5) == 0) stall_k = $urandom_range(1, n);
      run_txn(rw, op, len, adr, $urandom, br_k, stall_k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-side memory controller directly downstream of the load-store buffer. Accepts one load or store request at a time on the LSB's dc_* handshake. Serialises the request into byte-wide accesses on the unified RAM/IO port. Returns load data zero- or sign-extended to 32 bits, with a one-cycle completion pulse for both loads and stores.

Parameters:
ADR_W, 32, address width of request and memory port
DAT_W, 32, request data width (must be 32)
MEM_LAT, 1, RAM read latency in cycles (fixed; other values unsupported)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
en  in  1  global ready; low freezes all state and forces mem_wr_o=0
br_flag  in  1  misprediction flush
lsb_en_i  in  1  request valid (one-cycle pulse)
lsb_rwen_i  in  1  0=read (load), 1=write (store)
lsb_op_i  in  OP_W  opcode; selects LB/LH/LW/LBU/LHU signedness
lsb_len_i  in  3  access bytes: 1, 2 or 4
lsb_adr_i  in  ADR_W  byte address
lsb_dat_i  in  DAT_W  store data
lsb_en_o  out  1  completion pulse
lsb_dat_o  out  DAT_W  load result; 0 for stores
mem_din_i  in  8  RAM read byte, valid one cycle after its address
mem_dout_o  out  8  RAM write byte
mem_a_o  out  ADR_W  RAM byte address
mem_wr_o  out  1  1=write this cycle

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE.
  - lsb_en_o, lsb_dat_o, mem_dout_o, mem_a_o, mem_wr_o and cnt all 0.
  - An access in flight is abandoned. Reset takes priority over en.
- en=0: no register changes; mem_wr_o low.
- States: IDLE, READ, WRITE.
- IDLE, lsb_en_i=1 at cycle t:
  - Latch op, len, adr, dat. Set cnt=0.
  - Go to READ or WRITE per lsb_rwen_i.
  - lsb_len_i not in {1,2,4} is treated as 4.
- Requests arriving outside IDLE are ignored. The LSB never issues one, because it keeps its own dc_wait.
- WRITE, cycles t+1..t+L:
  - mem_a_o=adr+cnt, mem_dout_o=dat[8cnt+7:8cnt], mem_wr_o=1.
  - After the last byte: lsb_en_o=1 at t+L+1, lsb_dat_o=0, state=IDLE.
- READ, cycles t+1..t+L:
  - mem_a_o=adr+cnt, mem_wr_o=0.
  - Byte for address adr+k is sampled in cycle t+2+k into buf[8k+7:8k] (little-endian).
  - At t+L+2: lsb_en_o=1 and lsb_dat_o=extended result; state IDLE in that cycle.
- Extension:
  - LB sign-extends from bit 7; LH from bit 15.
  - LBU and LHU zero-extend; LW passes through.
- lsb_en_o is high for exactly one cycle per accepted, non-aborted request. It is low otherwise.
- A new request is accepted in the same cycle lsb_en_o is high, since state is already IDLE.
- Address arithmetic is ADR_W-bit modulo; wrap at 0xFFFFFFFF→0 is legal.
- mem_a_o holds its last value when idle; mem_wr_o is 0 whenever not in WRITE.
- br_flag=1 (with en=1):
  - In READ: abort. Next state IDLE, no lsb_en_o pulse, buffer discarded.
  - In WRITE: ignored. Committed stores always complete.
  - In IDLE with lsb_en_i=1 and rwen=0: request dropped.
  - In IDLE with lsb_en_i=1 and rwen=1: request accepted.
- No reads are speculative beyond the LSB head. IO addresses (0x30000+) are treated like RAM. The LSB already gates IO with iob_full.

Decomposition:
- head.v holds:
  - opcode constants LB, LH, LW, LBU, LHU, SB, SH, SW and OP_W;
  - state encodings DMC_IDLE, DMC_READ, DMC_WRITE;
  - IO_BASE 32'h30000.
- One natural sub-module is load_extend. It is combinational: 32-bit raw, op → 32-bit result. It is instantiated once and unit-tested separately.

Test Plan:
- LW at 0x100, RAM[0x100..0x103]=78 56 34 12, request at t → mem_a_o 0x100..0x103 at t+1..t+4; lsb_en_o=1 and lsb_dat_o=0x12345678 at t+6.
- LB vs LBU at 0x200, RAM=0x80 → LB returns 0xFFFFFF80, LBU returns 0x00000080, each at t+3.
- SH 0xBEEF to 0x3FE (no straddle issue) → mem_wr_o=1 with (0x3FE,EF) at t+1 and (0x3FF,BE) at t+2; lsb_en_o at t+3; RAM reads back 0xBEEF.
- LW in flight, br_flag=1 at t+2 → no lsb_en_o ever; state IDLE at t+3; a following SW accepted at t+3 completes normally.
- SW 0xDEADBEEF in flight, br_flag=1 at t+1 → all 4 bytes written; lsb_en_o at t+5.
- en low for 2 cycles mid-LW, then rst=0 during another LW → result delayed exactly 2 cycles; after reset all outputs 0 and no pulse.
